// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- RV32I instruction fetch controller
//
// Issues in-order fetch requests for the current pc, pairs each returned
// instruction word with its request address, and buffers the pair in a small
// FIFO for decode. Computes next_pc for the program counter register
// (pc+4 on an accepted request, the aligned redirect target on redirect,
// otherwise hold). A redirect flushes the FIFO and marks every response
// still in flight for dropping.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   defined   : a non-dropped response arriving while the FIFO is empty is
//               presented to decode in the same cycle (and is only pushed if
//               decode does not take it).
//   undefined : every response goes through the FIFO (one cycle of latency).
//
// Ports
//   clk, clr              clock (rising edge), asynchronous active-low reset
//   pc / next_pc          current fetch address / value pc loads next edge
//   redirect_valid/_pc    taken branch or jump from execute and its target
//   imem_req_*            request handshake to instruction memory (addr = pc)
//   imem_rsp_*            in-order response, one per accepted request
//   inst_valid/_ready     decode-side handshake
//   inst_data / inst_pc   instruction word at the head and its address
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1'b1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1'b1);
        end
    endfunction

    // Control state
    logic [CW-1:0] count_r, outstanding_r, drop_r;
    logic [PW-1:0] rd_ptr_r, wr_ptr_r, a_rd_ptr_r, a_wr_ptr_r;
    logic [31:0]   last_data_r, last_pc_r;

    // Storage: instruction FIFO and the address FIFO that pairs requests
    // with their responses.
    logic [31:0] data_mem_r [DEPTH];
    logic [31:0] pc_mem_r   [DEPTH];
    logic [31:0] addr_mem_r [DEPTH];

    // Combinational handshake terms
    logic [CW:0]   inflight_s;
    logic          req_valid_s, fire_s, rsp_take_s, rsp_keep_s;
    logic          fifo_empty_s, bypass_s, inst_valid_s;
    logic          pop_s, fifo_pop_s, push_s;
    logic [31:0]   rsp_addr_s, inst_data_s, inst_pc_s, next_pc_s;
    logic [CW-1:0] count_nx_s, outstanding_nx_s, drop_nx_s;

    // Target alignment drops the low bits of redirect_pc by design.
    logic unused_s;
    assign unused_s = ^redirect_pc[1:0];

    // Request credit, response classification and decode-side muxing.
    always_comb begin
        inflight_s   = {1'b0, outstanding_r} + {1'b0, count_r};
        // Credit counts every slot a response could still need, so a
        // returning word always has room in the FIFO.
        req_valid_s  = clr && !redirect_valid && (inflight_s < DEPTH_C);
        fire_s       = req_valid_s && imem_req_ready;
        // Responses with nothing outstanding belong to requests issued
        // before a reset and are ignored.
        rsp_take_s   = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
        rsp_keep_s   = rsp_take_s && (drop_r == {CW{1'b0}}) && !redirect_valid;
        rsp_addr_s   = addr_mem_r[a_rd_ptr_r];
        fifo_empty_s = (count_r == {CW{1'b0}});
`ifdef FETCH_BYPASS_EN
        bypass_s     = rsp_keep_s && fifo_empty_s;
`else
        bypass_s     = 1'b0;
`endif
        inst_valid_s = !redirect_valid && (!fifo_empty_s || bypass_s);
        pop_s        = inst_valid_s && inst_ready;
        fifo_pop_s   = pop_s && !fifo_empty_s;
        push_s       = rsp_keep_s && !(bypass_s && inst_ready);

        if (bypass_s) begin
            inst_data_s = imem_rsp_data;
            inst_pc_s   = rsp_addr_s;
        end else if (!fifo_empty_s) begin
            inst_data_s = data_mem_r[rd_ptr_r];
            inst_pc_s   = pc_mem_r[rd_ptr_r];
        end else begin
            // Empty: keep showing the last word handed to decode.
            inst_data_s = last_data_r;
            inst_pc_s   = last_pc_r;
        end

        if (redirect_valid) begin
            next_pc_s = {redirect_pc[31:2], 2'b00};
        end else if (fire_s) begin
            next_pc_s = pc + 32'd4;
        end else begin
            next_pc_s = pc;
        end
    end

    // Next values of the occupancy, in-flight and drop counters.
    always_comb begin
        count_nx_s       = count_r;
        outstanding_nx_s = outstanding_r;
        drop_nx_s        = drop_r;

        if (redirect_valid) begin
            count_nx_s = {CW{1'b0}};
        end else if (push_s && !fifo_pop_s) begin
            count_nx_s = count_r + ONE_C;
        end else if (!push_s && fifo_pop_s) begin
            count_nx_s = count_r - ONE_C;
        end else begin
            count_nx_s = count_r;
        end

        if (fire_s && !rsp_take_s) begin
            outstanding_nx_s = outstanding_r + ONE_C;
        end else if (!fire_s && rsp_take_s) begin
            outstanding_nx_s = outstanding_r - ONE_C;
        end else begin
            outstanding_nx_s = outstanding_r;
        end

        // No request fires in a redirect cycle, so everything still
        // outstanding after this edge is stale.
        if (redirect_valid) begin
            drop_nx_s = rsp_take_s ? (outstanding_r - ONE_C) : outstanding_r;
        end else if (rsp_take_s && (drop_r != {CW{1'b0}})) begin
            drop_nx_s = drop_r - ONE_C;
        end else begin
            drop_nx_s = drop_r;
        end
    end

    // Counters, pointers and the last-delivered word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            a_rd_ptr_r    <= {PW{1'b0}};
            a_wr_ptr_r    <= {PW{1'b0}};
            last_data_r   <= 32'h0000_0000;
            last_pc_r     <= 32'h0000_0000;
        end else begin
            count_r       <= count_nx_s;
            outstanding_r <= outstanding_nx_s;
            drop_r        <= drop_nx_s;
            if (redirect_valid) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (fifo_pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
            end
            // The address FIFO is never flushed: dropped responses still
            // consume their paired entry, keeping the pairing in order.
            if (fire_s) begin
                a_wr_ptr_r <= ptr_inc(a_wr_ptr_r);
            end
            if (rsp_take_s) begin
                a_rd_ptr_r <= ptr_inc(a_rd_ptr_r);
            end
            if (pop_s) begin
                last_data_r <= inst_data_s;
                last_pc_r   <= inst_pc_s;
            end
        end
    end

    // Data storage writes (payload only, no reset needed).
    always_ff @(posedge clk) begin
        if (fire_s) begin
            addr_mem_r[a_wr_ptr_r] <= pc;
        end
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rsp_data;
            pc_mem_r[wr_ptr_r]   <= rsp_addr_s;
        end
    end

    assign next_pc        = next_pc_s;
    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_s;
    assign inst_data      = inst_data_s;
    assign inst_pc        = inst_pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// The bench owns the pc register and a variable-latency instruction memory.
// Its reference model tracks, per cycle, the requests in flight (tagged with a
// redirect generation), the number of buffered words and the ordered list of
// words decode is still owed, and derives every expected output from those.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] pc, next_pc, redirect_pc, imem_req_addr, imem_rsp_data;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, inst_valid, inst_ready;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .clr            (clr),
        .pc             (pc),
        .next_pc        (next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          gen;
    } mem_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ins_t;

    mem_t memq[$];
    ins_t exp_q[$];
    int   cyc, gen, buf_n, lat_min, lat_max, last_due;
    int   n_assert, n_fail, obs_fires, n_deliv;
    bit   force_en, saw_deliv;
    logic [31:0] force_data, obs_next, obs_pc, obs_addr, last_deliv_pc;
    logic        obs_iv, obs_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present memory response, check outputs mid-cycle,
    // then advance the model and pc after the edge.
    task automatic step();
        bit          rsp_live, exp_req, exp_byp, exp_iv, exp_fire, deliv;
        logic [31:0] exp_next, d;
        int          due;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        rsp_live = imem_rsp_valid && clr && (memq[0].gen == gen) && !redirect_valid;
        exp_req  = clr && !redirect_valid && (memq.size() + buf_n < DEPTH);
        exp_byp  = BYP && rsp_live && (buf_n == 0);
        exp_iv   = clr && !redirect_valid && (buf_n > 0 || exp_byp);
        exp_fire = exp_req && imem_req_ready;
        exp_next = redirect_valid ? {redirect_pc[31:2], 2'b00}
                 : (exp_fire ? pc + 32'd4 : pc);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        chk("next_pc", next_pc, exp_next);
        if (exp_req) chk("req_addr", imem_req_addr, pc);
        if (exp_iv && exp_q.size() > 0) begin
            chk("inst_pc", inst_pc, exp_q[0].addr);
            chk("inst_data", inst_data, exp_q[0].data);
        end
        obs_next = next_pc;
        obs_pc   = pc;
        obs_iv   = inst_valid;
        obs_req  = imem_req_valid;
        obs_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) obs_fires++;
        deliv = exp_iv && inst_ready;
        @(posedge clk);
        #1;
        if (deliv && exp_q.size() > 0) begin
            last_deliv_pc = exp_q[0].addr;
            saw_deliv = 1'b1;
            n_deliv++;
            void'(exp_q.pop_front());
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        buf_n = buf_n + int'(rsp_live) - int'(deliv);
        if (redirect_valid) begin
            gen++;
            exp_q.delete();
            buf_n = 0;
        end
        if (exp_fire) begin
            d   = force_en ? force_data : (pc ^ KEY);
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{pc, d, due, gen});
            exp_q.push_back('{pc, d});
        end
        pc = clr ? exp_next : 32'h0;
        cyc++;
    endtask

    // Let everything in flight return and be consumed, with a cycle bound.
    task automatic drain();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (memq.size() == 0 && buf_n == 0) break;
            step();
        end
        chk("drain_empty", 32'(memq.size() + buf_n), 32'h0);
    endtask

    // Hold reset for two cycles, release, and check the first request.
    task automatic reset_and_release();
        memq.delete();
        exp_q.delete();
        buf_n = 0;
        gen++;
        pc = 32'h0;
        last_due = cyc;
        redirect_valid = 1'b0;
        repeat (2) step();
        clr = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        step();
        chk("first_req_valid", 32'(obs_req), 32'h1);
        chk("first_req_addr", obs_addr, 32'h0);
        chk("first_next_pc", obs_next, 32'h4);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; gen = 0; buf_n = 0; last_due = 0;
        obs_fires = 0; n_deliv = 0; force_en = 1'b0; force_data = 32'h0;
        saw_deliv = 1'b0; last_deliv_pc = 32'h0; lat_min = 1; lat_max = 1;
        clr = 1'b0; pc = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; inst_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        #1;
        chk("reset_inst_valid", 32'(inst_valid), 32'h0);
        chk("reset_req_valid", 32'(imem_req_valid), 32'h0);
        chk("reset_next_pc", next_pc, 32'h0);
        reset_and_release();

        // Streaming with a 1-cycle memory and decode always ready
        repeat (30) step();
        chk("stream_progress", 32'(n_deliv >= 12), 32'h1);

        // Backpressure: decode stalls for 10 cycles
        drain();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        obs_fires = 0;
        repeat (10) step();
        chk("bp_fires", 32'(obs_fires), 32'h2);
        chk("bp_req_valid", 32'(obs_req), 32'h0);
        chk("bp_pc_hold", obs_next, obs_pc);
        inst_ready = 1'b1;
        repeat (8) step();

        // Redirect with two requests in flight on a 3-cycle memory
        drain();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (memq.size() >= 2) break;
            step();
        end
        chk("two_inflight", 32'(memq.size()), 32'h2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        chk("redir_next_pc", obs_next, 32'h0000_0100);
        redirect_valid = 1'b0;
        saw_deliv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (saw_deliv) break;
            step();
        end
        chk("redir_delivered", 32'(saw_deliv), 32'h1);
        chk("redir_first_pc", last_deliv_pc, 32'h0000_0100);

        // Wrap-around of the fetch address
        drain();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_next_pc", obs_next, 32'h0);
        repeat (6) step();

        // Empty-FIFO response with data 0x13: same-cycle or next-cycle valid
        drain();
        force_en = 1'b1;
        force_data = 32'h0000_0013;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        chk("byp_rsp_cycle_iv", 32'(obs_iv), 32'(BYP));
        step();
        chk("byp_next_cycle_iv", 32'(obs_iv), 32'(!BYP));
        force_en = 1'b0;

        // Random traffic with redirects
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom;
            step();
        end

        // Asynchronous reset in the middle of traffic
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) step();
        clr = 1'b0;
        #1;
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        reset_and_release();
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
